// File: rtl/ifft_pkg.sv
// Shared constants and types for the IFFT datapath: component widths, twiddle
// Q-format and the complex sample container.
package ifft_pkg;

    localparam int DATA_W  = 16;
    localparam int TW_W    = 16;
    localparam int TW_FRAC = 8;
    localparam int ADDR_W  = 5;

    localparam logic [TW_W-1:0] ONE = 16'h0100;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/ifft_round_sat.sv
// Round-half-up arithmetic right shift of a wide signed value, then clamp to the
// signed OUT_W range, flagging when the clamp engaged.
module ifft_round_sat
    import ifft_pkg::*;
#(
    parameter int IN_W  = DATA_W + TW_W + 1,
    parameter int OUT_W = DATA_W,
    parameter int FRAC  = TW_FRAC
) (
    input  logic signed [IN_W-1:0]  in_i,
    output logic signed [OUT_W-1:0] out_o,
    output logic                    sat_o
);

    // One guard bit so adding the half-LSB can never wrap.
    localparam int SW = IN_W + 1;
    localparam logic signed [SW-1:0] HALF  = SW'(1) <<< (FRAC - 1);
    localparam logic signed [SW-1:0] MAX_V = SW'((longint'(1) <<< (OUT_W - 1)) - 1);
    localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

    logic signed [SW-1:0] biased;
    logic signed [SW-1:0] shifted;

    assign biased  = SW'(in_i) + HALF;
    assign shifted = biased >>> FRAC;

    always_comb begin
        out_o = shifted[OUT_W-1:0];
        sat_o = 1'b0;
        if (shifted > MAX_V) begin
            out_o = MAX_V[OUT_W-1:0];
            sat_o = 1'b1;
        end else if (shifted < MIN_V) begin
            out_o = MIN_V[OUT_W-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/ifft_twiddle_mult.sv
// Three-stage complex twiddle multiplier (sample x W) between the twiddle ROMs and
// the butterfly; one global advance enable gives full rate with backpressure.
module ifft_twiddle_mult
    import ifft_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  logic [ADDR_W-1:0]        in_tw_addr,
    input  logic                     in_last,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic signed [TW_W-1:0]   rom_re_data,
    input  logic signed [TW_W-1:0]   rom_im_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     out_last,
    output logic                     out_sat
);

    localparam int PW = DATA_W + TW_W;
    localparam int SW = PW + 1;

    logic                 en;
    logic [ADDR_W-1:0]    addr_hold_q;
    logic                 s1_valid_q, s1_last_q;
    cplx_t                s1_q;
    logic                 s2_valid_q, s2_last_q;
    logic signed [PW-1:0] ac_q, bd_q, ad_q, bc_q;
    logic                 out_valid_q, out_last_q, out_sat_q;
    cplx_t                out_q;

    logic signed [SW-1:0] re_wide_d, im_wide_d;
    cplx_t                res_d;
    logic                 sat_re_d, sat_im_d;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;
    // Re-presenting the held address on a stall keeps the ROM output aligned with S1.
    assign rom_addr = en ? in_tw_addr : addr_hold_q;

    assign re_wide_d = SW'(ac_q) - SW'(bd_q);
    assign im_wide_d = SW'(ad_q) + SW'(bc_q);

    ifft_round_sat #(.IN_W(SW), .OUT_W(DATA_W), .FRAC(TW_FRAC)) u_rs_re (
        .in_i  (re_wide_d),
        .out_o (res_d.re),
        .sat_o (sat_re_d)
    );

    ifft_round_sat #(.IN_W(SW), .OUT_W(DATA_W), .FRAC(TW_FRAC)) u_rs_im (
        .in_i  (im_wide_d),
        .out_o (res_d.im),
        .sat_o (sat_im_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hold_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_q        <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            ac_q        <= '0;
            bd_q        <= '0;
            ad_q        <= '0;
            bc_q        <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_sat_q   <= 1'b0;
            out_q       <= '0;
        end else if (en) begin
            addr_hold_q <= in_tw_addr;
            s1_valid_q  <= in_valid;
            s1_last_q   <= in_last;
            s1_q.re     <= in_re;
            s1_q.im     <= in_im;
            s2_valid_q  <= s1_valid_q;
            s2_last_q   <= s1_last_q;
            ac_q        <= $signed(s1_q.re) * rom_re_data;
            bd_q        <= $signed(s1_q.im) * rom_im_data;
            ad_q        <= $signed(s1_q.re) * rom_im_data;
            bc_q        <= $signed(s1_q.im) * rom_re_data;
            out_valid_q <= s2_valid_q;
            out_last_q  <= s2_last_q;
            out_sat_q   <= sat_re_d || sat_im_d;
            out_q       <= res_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_q.re;
    assign out_im    = out_q.im;
    assign out_last  = out_last_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_ifft_twiddle_mult.sv
// Bench for ifft_twiddle_mult: behavioural ROM, queue-based arithmetic reference,
// directed literal cases, backpressure burst, mid-stream reset and a random run.
module tb_ifft_twiddle_mult;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid, in_ready, in_last;
    logic signed [15:0] in_re, in_im;
    logic [4:0]         in_tw_addr, rom_addr;
    logic signed [15:0] rom_re_data, rom_im_data;
    logic               out_valid, out_ready, out_last, out_sat;
    logic signed [15:0] out_re, out_im;

    logic signed [15:0] rom_re_mem [32];
    logic signed [15:0] rom_im_mem [32];

    typedef struct {
        int re;
        int im;
        bit last;
        bit sat;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         out_cnt  = 0;
    logic [4:0] hold_m   = '0;
    bit         rnd_done = 1'b0;

    ifft_twiddle_mult dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_tw_addr(in_tw_addr), .in_last(in_last),
        .rom_addr(rom_addr), .rom_re_data(rom_re_data), .rom_im_data(rom_im_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_last(out_last), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_re_data <= rom_re_mem[rom_addr];
        rom_im_data <= rom_im_mem[rom_addr];
    end

    function automatic int rnd_sat(input longint v, output bit s);
        longint q;
        q = (v + 128) >>> 8;
        s = 1'b0;
        if (q > 32767)  begin q = 32767;  s = 1'b1; end
        if (q < -32768) begin q = -32768; s = 1'b1; end
        return int'(q);
    endfunction

    function automatic exp_t model(input int a, input int b, input int c, input int d, input bit last);
        exp_t e;
        bit   s_re, s_im;
        e.re   = rnd_sat(longint'(a) * c - longint'(b) * d, s_re);
        e.im   = rnd_sat(longint'(a) * d + longint'(b) * c, s_im);
        e.last = last;
        e.sat  = s_re | s_im;
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference tracking and output comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_m = '0;
        end else begin
            if (in_valid && in_ready)
                exp_q.push_back(model(int'(in_re), int'(in_im), int'(rom_re_mem[in_tw_addr]),
                                      int'(rom_im_mem[in_tw_addr]), in_last));
            checks++;
            if (rom_addr != (in_ready ? in_tw_addr : hold_m)) begin
                failures++;
                $display("FAIL rom_addr: got %0d expected %0d", rom_addr, in_ready ? in_tw_addr : hold_m);
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_in_ready: got %b expected 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                out_cnt++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL stale_beat: got out (%0d,%0d) expected no beat", out_re, out_im);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (int'(out_re) != e.re || int'(out_im) != e.im || out_last != e.last || out_sat != e.sat) begin
                        failures++;
                        $display("FAIL beat%0d: got (%0d,%0d) last=%b sat=%b expected (%0d,%0d) last=%b sat=%b",
                                 out_cnt, out_re, out_im, out_last, out_sat, e.re, e.im, e.last, e.sat);
                    end
                end
            end
            if (in_ready) hold_m = in_tw_addr;
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send(input logic [4:0] addr, input int a, input int b, input bit last);
        int n;
        in_valid   = 1'b1;
        in_tw_addr = addr;
        in_re      = 16'(a);
        in_im      = 16'(b);
        in_last    = last;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) begin
            failures++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_one(input string name, input logic [4:0] addr, input int a, input int b,
                              input int er, input int ei, input bit es);
        int n;
        send(addr, a, b, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk({name, "_latency"}, n, 3);
        chk({name, "_re"}, out_re, er);
        chk({name, "_im"}, out_im, ei);
        chk({name, "_sat"}, out_sat, es);
        chk({name, "_last"}, out_last, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_re = '0; in_im = '0;
        in_tw_addr = '0; out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rom_re_mem[i] = '0;
            rom_im_mem[i] = '0;
        end
        rom_re_mem[0] = 16'sh0100;
        rom_re_mem[1] = 16'sh0100;
        rom_im_mem[2] = 16'sh0100;
        rom_re_mem[3] = 16'sh00B5; rom_im_mem[3] = 16'sh00B5;
        rom_re_mem[4] = 16'sh0080;

        repeat (3) @(posedge clk);
        #1;
        in_tw_addr = 5'd9;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rom_addr", rom_addr, 9);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        expect_one("identity",  1, 100,   -50,   100, -50,   0);
        expect_one("rotate",    2, 100,   -50,   50,  100,   0);
        expect_one("deg45",     3, 256,   0,     181, 181,   0);
        expect_one("deg45_sat", 3, 32767, 32767, 0,   32767, 1);
        expect_one("round_p1",  4, 1,     0,     1,   0,     0);
        expect_one("round_m1",  4, -1,    0,     0,   0,     0);
        expect_one("round_m3",  4, -3,    0,     -1,  0,     0);
        expect_one("zero_tw",   5, 1234,  -999,  0,   0,     0);

        // Eight-beat burst, downstream stalls for five cycles after the second result.
        begin
            int base;
            base = out_cnt;
            fork
                begin
                    for (int k = 0; k < 8; k++)
                        send(5'(1 + k % 4), int'($urandom_range(0, 4000)) - 2000,
                             int'($urandom_range(0, 4000)) - 2000, k == 7);
                end
                begin
                    int n;
                    n = 0;
                    while (out_cnt < base + 2 && n < 100) begin
                        @(posedge clk);
                        n++;
                    end
                    chk("bp_second_beat", (out_cnt >= base + 2) ? 1 : 0, 1);
                    @(posedge clk);
                    #1;
                    out_ready = 1'b0;
                    repeat (5) @(posedge clk);
                    #1;
                    out_ready = 1'b1;
                end
            join
            drain("burst");
            chk("burst_count", out_cnt - base, 8);
        end

        // Reset with beats in flight; nothing stale may appear afterwards.
        send(1, 10, 20, 1'b0);
        send(2, 30, 40, 1'b0);
        send(3, 50, 60, 1'b0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_re", out_re, 0);
        chk("midrst_out_im", out_im, 0);
        chk("midrst_out_sat", out_sat, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_one("post_rst", 0, 7, 7, 7, 7, 0);

        // Random traffic with random ROM contents and random backpressure.
        for (int i = 0; i < 32; i++) begin
            rom_re_mem[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 512) - 256);
            rom_im_mem[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 512) - 256);
        end
        begin
            int base;
            base = out_cnt;
            fork
                begin
                    for (int k = 0; k < 300; k++) begin
                        repeat ($urandom_range(0, 2)) begin
                            in_tw_addr = 5'($urandom);
                            @(posedge clk);
                            #1;
                        end
                        send(5'($urandom), int'($urandom_range(0, 65535)) - 32768,
                             int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 7) == 0);
                    end
                    rnd_done = 1'b1;
                end
                begin
                    while (!rnd_done) begin
                        @(posedge clk);
                        #1;
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                    out_ready = 1'b1;
                end
            join
            drain("random");
            chk("random_count", out_cnt - base, 300);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
